// File: rtl/seg_7_pkg.sv
// Shared definitions for the seg_7_n_scan display driver: segment patterns,
// converter state encoding and small constant helpers.
package seg_7_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } conv_state_e;

  // Segment order is {a,b,c,d,e,f,g}; a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic int unsigned pow10(input int n);
    int unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one shift per clock,
// W shifts per conversion, plus an overflow flag for values beyond N digits.
module bin2bcd_seq
  import seg_7_pkg::*;
#(
  parameter int W = 10,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   bin,
  output logic [4*N-1:0] bcd,
  output logic           done,
  output logic           busy,
  output logic           ovf
);

  localparam int SRW = 4 * N + W;
  localparam int CW  = $clog2(W);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(W - 1);
  localparam int unsigned MAX_SHOWN = pow10(N) - 1;

  conv_state_e    state_q, state_d;
  logic [SRW-1:0] sr_q, sr_d, adj;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    adj     = sr_q;
    for (int k = 0; k < N; k++) begin
      if (adj[W+4*k +: 4] >= 4'd5) adj[W+4*k +: 4] = adj[W+4*k +: 4] + 4'd3;
    end
    case (state_q)
      S_IDLE: begin
        // Starts arriving in SHIFT or DONE are dropped, not queued.
        if (start) begin
          sr_d    = {{(4 * N){1'b0}}, bin};
          cnt_d   = '0;
          ovf_d   = (32'(bin) > MAX_SHOWN);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_d  = adj << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_SHIFT) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bcd  = sr_q[SRW-1 -: 4*N];
  assign done = (state_q == S_DONE);
  assign busy = (state_q != S_IDLE);
  assign ovf  = ovf_q;

endmodule

// File: rtl/seg_7_n_scan.sv
// Multiplexed N-digit seven-segment driver for an unsigned binary value.
// Define SEG_LZ_BLANK_EN to blank leading zeros on digits above the units.
module seg_7_n_scan
  import seg_7_pkg::*;
#(
  parameter int W          = 10,
  parameter int N          = 4,
  parameter int SCAN_DIV   = 500000,
  parameter int SAMPLE_DIV = 5000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] value,
  output logic [N-1:0] an_n,
  output logic [6:0]   seg,
  output logic         ovf,
  output logic         busy
);

  localparam int SMW = $clog2(SAMPLE_DIV);
  localparam int SCW = $clog2(SCAN_DIV);
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [SMW-1:0] SAMPLE_MAX = SMW'(SAMPLE_DIV - 1);
  localparam logic [SCW-1:0] SCAN_MAX   = SCW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]  IDX_MAX    = IW'(N - 1);

  logic [SMW-1:0] samp_q, samp_d;
  logic [SCW-1:0] scan_q, scan_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N-1:0]   an_n_q, an_n_d;
  logic [4*N-1:0] disp_q, disp_d;
  logic           ovf_q, ovf_d;
  logic           tick, slot_end;
  logic [4*N-1:0] conv_bcd;
  logic           conv_done, conv_ovf;
  logic [3:0]     digit;
  logic           blank;

  bin2bcd_seq #(
    .W(W),
    .N(N)
  ) u_conv (
    .clk  (clk),
    .rst  (rst),
    .start(tick),
    .bin  (value),
    .bcd  (conv_bcd),
    .done (conv_done),
    .busy (busy),
    .ovf  (conv_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q <= '0;
      scan_q <= '0;
      idx_q  <= '0;
      an_n_q <= ~N'(1);
      disp_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      samp_q <= samp_d;
      scan_q <= scan_d;
      idx_q  <= idx_d;
      an_n_q <= an_n_d;
      disp_q <= disp_d;
      ovf_q  <= ovf_d;
    end
  end

  always_comb begin
    tick     = (samp_q == SAMPLE_MAX);
    samp_d   = tick ? '0 : samp_q + 1'b1;
    slot_end = (scan_q == SCAN_MAX);
    scan_d   = slot_end ? '0 : scan_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    // Anode enable is registered alongside the index it decodes.
    an_n_d   = ~(N'(1) << idx_d);
    disp_d   = conv_done ? conv_bcd : disp_q;
    ovf_d    = conv_done ? conv_ovf : ovf_q;
  end

`ifdef SEG_LZ_BLANK_EN
  logic [N-1:0] lead_zero;
  logic         zero_run;

  // lead_zero[i] is set when digit i and every digit above it are zero.
  always_comb begin
    zero_run  = 1'b1;
    lead_zero = '0;
    for (int i = N - 1; i >= 0; i--) begin
      zero_run     = zero_run & (disp_q[4*i +: 4] == 4'd0);
      lead_zero[i] = zero_run;
    end
    blank = (idx_q != '0) && lead_zero[idx_q];
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    digit = disp_q[4*idx_q +: 4];
    if (ovf_q)      seg = SEG_DASH;
    else if (blank) seg = SEG_BLANK;
    else            seg = seg_decode(digit);
  end

  assign an_n = an_n_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seg_7_n_scan.sv
// Scoreboard bench for seg_7_n_scan: a 4-digit and a 3-digit instance share
// clock and reset; expected digit patterns are queued at each sample tick.
module tb_seg_7_n_scan;

  localparam int W          = 10;
  localparam int SCAN_DIV   = 4;
  localparam int SAMPLE_DIV = 20;

  typedef struct packed {
    logic            ovf;
    logic [3:0][6:0] seg;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] value4, value3;
  logic [3:0]   an_n4;
  logic [2:0]   an_n3;
  logic [6:0]   seg4, seg3;
  logic         ovf4, ovf3, busy4, busy3;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q4[$];
  exp_t q3[$];
  exp_t cur4, cur3;
  int   done_cnt = 0;
  int   seen_cnt = 0;
  int   samp_m, scan_m, idx4_m, idx3_m, busy_m;

  seg_7_n_scan #(.W(W), .N(4), .SCAN_DIV(SCAN_DIV), .SAMPLE_DIV(SAMPLE_DIV)) dut4 (
    .clk(clk), .rst(rst), .value(value4), .an_n(an_n4), .seg(seg4), .ovf(ovf4), .busy(busy4)
  );

  seg_7_n_scan #(.W(W), .N(3), .SCAN_DIV(SCAN_DIV), .SAMPLE_DIV(SAMPLE_DIV)) dut3 (
    .clk(clk), .rst(rst), .value(value3), .an_n(an_n3), .seg(seg3), .ovf(ovf3), .busy(busy3)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int unsigned max_shown(input int n);
    int unsigned r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r - 1;
  endfunction

  function automatic exp_t expect_of(input int unsigned v, input int n);
    exp_t        e;
    int unsigned r;
    int          dg[4];
    logic        blank;
`ifdef SEG_LZ_BLANK_EN
    bit          zero_run = 1'b1;
`endif
    e     = '0;
    r     = v;
    e.ovf = (v > max_shown(n));
    for (int i = 0; i < 4; i++) begin
      dg[i] = int'(r % 10);
      r     = r / 10;
    end
    for (int i = n - 1; i >= 0; i--) begin
      blank = 1'b0;
`ifdef SEG_LZ_BLANK_EN
      zero_run = zero_run && (dg[i] == 0);
      blank    = (i > 0) && zero_run;
`endif
      if (e.ovf)      e.seg[i] = 7'b1111110;
      else if (blank) e.seg[i] = 7'b1111111;
      else            e.seg[i] = seg_of(dg[i]);
    end
    return e;
  endfunction

  // Reference timeline: sample tick, converter occupancy, scan index.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      samp_m = 0; scan_m = 0; idx4_m = 0; idx3_m = 0; busy_m = 0; done_cnt = 0;
    end else begin
      if (busy_m > 0) begin
        busy_m--;
        if (busy_m == 0) done_cnt++;
      end else if (samp_m == SAMPLE_DIV - 1) begin
        busy_m = W + 1;
        q4.push_back(expect_of(int'(value4), 4));
        q3.push_back(expect_of(int'(value3), 3));
      end
      samp_m = (samp_m == SAMPLE_DIV - 1) ? 0 : samp_m + 1;
      if (scan_m == SCAN_DIV - 1) begin
        scan_m = 0;
        idx4_m = (idx4_m + 1) % 4;
        idx3_m = (idx3_m + 1) % 3;
      end else begin
        scan_m++;
      end
    end
  end

  // Monitor: retire finished conversions, then compare every output each cycle.
  initial forever begin
    logic [3:0] e_an4;
    logic [2:0] e_an3;
    @(negedge clk);
    if (rst) begin
      q4.delete();
      q3.delete();
      seen_cnt = 0;
      cur4 = expect_of(0, 4);
      cur3 = expect_of(0, 3);
    end else begin
      while (seen_cnt < done_cnt) begin
        seen_cnt++;
        if (q4.size() == 0 || q3.size() == 0) begin
          check("scoreboard_empty", 32'(q4.size() + q3.size()), 32'd2);
        end else begin
          cur4 = q4.pop_front();
          cur3 = q3.pop_front();
        end
      end
    end
    e_an4 = ~(4'b0001 << idx4_m);
    e_an3 = ~(3'b001 << idx3_m);
    check("busy4", 32'(busy4), 32'(busy_m != 0));
    check("busy3", 32'(busy3), 32'(busy_m != 0));
    check("an_n4", 32'(an_n4), 32'(e_an4));
    check("an_n3", 32'(an_n3), 32'(e_an3));
    check("seg4",  32'(seg4),  32'(cur4.seg[idx4_m]));
    check("seg3",  32'(seg3),  32'(cur3.seg[idx3_m]));
    check("ovf4",  32'(ovf4),  32'(cur4.ovf));
    check("ovf3",  32'(ovf3),  32'(cur3.ovf));
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    value4 = '0;
    value3 = '0;
    wait_neg(3);
    #2 rst = 1'b0;

    // 987 / 1023(ovf on 3 digits); changed to 7 / 5 mid-conversion.
    value4 = 10'd987;
    value3 = 10'd1023;
    wait_neg(25);
    value4 = 10'd7;
    value3 = 10'd5;
    wait_neg(20);
    value4 = 10'd0;
    value3 = 10'd999;
    wait_neg(20);
    value4 = 10'd1023;
    value3 = 10'd1000;
    wait_neg(20);
    value4 = 10'd500;
    value3 = 10'd0;
    wait_neg(40);

    // Abort a conversion three shifts in.
    for (int k = 0; k < 200 && busy_m != 8; k++) @(negedge clk);
    check("shift_busy", 32'(busy4), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_busy3", 32'(busy3), 32'd0);
    check("rst_an_n4", 32'(an_n4), 32'h0000_000e);
    check("rst_an_n3", 32'(an_n3), 32'h0000_0006);
    check("rst_seg4",  32'(seg4),  32'h0000_0001);
    check("rst_ovf4",  32'(ovf4),  32'd0);
    wait_neg(2);
    #2 rst = 1'b0;
    value4 = 10'd42;
    value3 = 10'd77;
    wait_neg(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
